issue_decode: RTL and testbench
===============================

# issue_decode

Decode and operand-issue stage directly upstream of the execute ALU. It accepts 32-bit instruction words over a valid/ready handshake and owns the 32 x 64-bit integer register file. It tracks pending writes with a per-register busy scoreboard and presents registered operand1/operand2/op/label/label_en/rd to execute. Results return through a writeback port.

## Interface
- XLEN, 64, register and operand width
- NREG, 32, register count; register addresses are 5 bits

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instr is valid
- in_ready  out  1  stage accepts instr this cycle
- instr  in  32  [31:27] op, [26:22] rd, [21:17] rs, [16:12] rt, [11:0] label
- wb_en  in  1  writeback strobe
- wb_addr  in  5  writeback register
- wb_data  in  XLEN  writeback value
- out_valid  out  1  issue register holds an instruction for execute
- out_ready  in  1  execute consumes the issue register this cycle
- operand1, operand2  out  XLEN  source values to execute
- op  out  5  opcode, passed through
- label  out  12  instr[11:0], passed through
- label_en  out  1  immediate opcode
- rd  out  5  destination register, carried for writeback
- illegal  out  1  one-cycle pulse: an illegal opcode was dropped

## Operation
- Opcodes 0–13 are legal. Opcodes 14–31 are illegal.
- label_en = 1 for op 1 (addi), 3 (subi), 12 (shftri), 13 (shftli); 0 for all other opcodes.
- Source selection:
  - Immediate ops: src1 = rd field; no src2; operand2 = 0.
  - All other legal ops: src1 = rs, src2 = rt. op 9 (not) also reads rt; execute ignores it.
- r0 reads as 0. Writes to r0 are ignored, and r0 is never busy.
- Write-through bypass: when wb_en=1 and wb_addr equals a source this cycle, that source reads wb_data, and the register is treated as not busy for the hazard check.
- Hazard condition: the instruction is legal and any of busy[src1], busy[src2] or busy[rd] is set, after applying the bypass.
- in_ready = (!out_valid || out_ready) && !hazard. Illegal opcodes ignore the hazard term.
- Accept (in_valid && in_ready):
  - Legal op: load the issue register, set out_valid, set busy[rd] when rd != 0.
  - Illegal op: consume the word, leave the issue register unchanged, and pulse illegal on the next cycle.
- Writeback with wb_en=1 and wb_addr != 0: reg[wb_addr] <= wb_data and busy[wb_addr] is cleared.
- Same-cycle set (accept) and clear (writeback) of the same busy bit: set wins.
- out_ready with no accept in the same cycle: out_valid returns to 0. Outputs hold their values until the next accept.
- While out_valid=1 and out_ready=0, all outputs hold stable.

## Timing
- Reset: out_valid=0, illegal=0, operand1/operand2/op/label/label_en/rd all 0, every register 0, every busy bit 0. in_ready is 1 immediately after reset release.
- Reset asserted mid-operation clears everything asynchronously. Instructions in flight and pending writebacks are lost.
- Latency: accept in cycle N gives out_valid=1 in N+1. Sustained throughput is 1 instruction per cycle when there are no hazards and out_ready=1.
- A dependent instruction stalls from the cycle after its producer is accepted until the producer's writeback cycle. It is accepted in that writeback cycle, with the bypassed data.
- illegal is high for exactly one cycle, N+1, after an illegal op is accepted in cycle N.
- Register file and busy bits update at the clock edge. The bypass is combinational from wb_* to the issue-register D inputs and to in_ready.

## Test plan
- Reset, write r1=5 and r2=7 via wb, then issue add r3,r1,r2 (op 0) -> next cycle: out_valid=1, operand1=5, operand2=7, rd=3, label_en=0, busy[3]=1.
- Issue addi r4,L=0x123 with r4=10 -> operand1=10, operand2=0, label=0x123, label_en=1.
- Issue add r3,r1,r2 then sub r5,r3,r1 with wb of r3=12 delayed 4 cycles -> in_ready=0 for those cycles. The sub is accepted in the wb cycle with operand1=12 (bypass).
- Hold out_ready=0 for 3 cycles while out_valid=1 -> outputs stable, in_ready=0, and no new accept. Release -> one issue per cycle resumes.
- Present op=20 -> word consumed, out_valid unchanged, illegal=1 for exactly one cycle.
- Assert rst_n=0 while busy[3]=1 and out_valid=1 -> all outputs 0 and busy cleared. After release, an instruction reading r3 is accepted at once with operand 0.

Source files
------------

// File: rtl/issue_decode.sv
// Decode and operand-issue stage: owns the integer register file and a per-register
// busy scoreboard, and presents registered operands to the execute ALU.
module issue_decode #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] operand1,
    output logic [XLEN-1:0] operand2,
    output logic [4:0]      op,
    output logic [11:0]     label,
    output logic            label_en,
    output logic [4:0]      rd,
    output logic            illegal
);

    localparam logic [4:0] LAST_LEGAL_OP = 5'd13;

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;

    logic [4:0]  f_op, f_rd, f_rs, f_rt;
    logic [11:0] f_label;
    assign {f_op, f_rd, f_rs, f_rt, f_label} = instr;

    logic            legal, imm;
    logic [4:0]      src1, src2;
    logic [XLEN-1:0] src1_val, src2_val;
    logic            hazard, accept, load;

    // A register being written back this cycle reads the new value and is no longer pending.
    function automatic logic [XLEN-1:0] read_src(input logic [4:0] a);
        if (a == '0)                    return '0;
        else if (wb_en && wb_addr == a) return wb_data;
        else                            return regs[a];
    endfunction

    function automatic logic pending(input logic [4:0] a);
        return (a != '0) && busy[a] && !(wb_en && wb_addr == a);
    endfunction

    always_comb begin
        legal    = (f_op <= LAST_LEGAL_OP);
        imm      = f_op inside {5'd1, 5'd3, 5'd12, 5'd13};
        // Immediate forms read rd as their source; r0 stands in for the absent second source.
        src1     = imm ? f_rd : f_rs;
        src2     = imm ? 5'd0 : f_rt;
        src1_val = read_src(src1);
        src2_val = read_src(src2);
        hazard   = legal && (pending(src1) || pending(src2) || pending(f_rd));
    end

    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;
    assign load     = accept && legal;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            operand1  <= '0;
            operand2  <= '0;
            op        <= '0;
            label     <= '0;
            label_en  <= 1'b0;
            rd        <= '0;
            illegal   <= 1'b0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                operand1  <= src1_val;
                operand2  <= src2_val;
                op        <= f_op;
                label     <= f_label;
                label_en  <= imm;
                rd        <= f_rd;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            illegal <= accept && !legal;
        end
    end

    // NOTE: the register file is reset explicitly because software relies on every register reading 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_en && wb_addr != '0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // A new producer claiming rd outranks a writeback retiring the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (load && f_rd == i[4:0])
                    busy[i] <= 1'b1;
                else if (wb_en && wb_addr == i[4:0])
                    busy[i] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_issue_decode.sv
// Scoreboard bench for issue_decode: a register-file/pending-set model predicts
// handshakes and issued operands; a monitor compares each consumed issue.
module tb_issue_decode;

    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [31:0] instr;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic        out_valid, out_ready;
    logic [63:0] operand1, operand2;
    logic [4:0]  op, rd;
    logic [11:0] label;
    logic        label_en, illegal;

    issue_decode dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .operand1(operand1), .operand2(operand2), .op(op),
        .label(label), .label_en(label_en), .rd(rd), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] op1;
        logic [63:0] op2;
        logic [4:0]  op;
        logic [11:0] label;
        logic        label_en;
        logic [4:0]  rd;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;

    logic [63:0] m_regs [32];
    bit          m_busy [32];
    bit          m_valid;
    bit          m_illegal;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input int o, input int d, input int s, input int t, input int l);
        logic [4:0]  o5 = o[4:0];
        logic [4:0]  d5 = d[4:0];
        logic [4:0]  s5 = s[4:0];
        logic [4:0]  t5 = t[4:0];
        logic [11:0] l12 = l[11:0];
        return {o5, d5, s5, t5, l12};
    endfunction

    function automatic logic [63:0] m_read(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [63:0] wd);
        if (a == 0) return 64'd0;
        if (we && wa == a) return wd;
        return m_regs[a];
    endfunction

    function automatic bit m_pending(input logic [4:0] a, input logic we, input logic [4:0] wa);
        return (a != 0) && m_busy[a] && !(we && wa == a);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 64'd0;
            m_busy[i] = 1'b0;
        end
        m_valid   = 1'b0;
        m_illegal = 1'b0;
        exp_q.delete();
    endtask

    // One clock cycle: drive, predict, check handshake at negedge, advance the model at posedge.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic we,
                         input logic [4:0] wa, input logic [63:0] wd, input logic ordy);
        logic [4:0] o, d, s, t, s1, s2;
        bit         lg, im, rdy, acc;
        exp_t       e;
        in_valid = v; instr = ins; wb_en = we; wb_addr = wa; wb_data = wd; out_ready = ordy;
        o  = ins[31:27]; d = ins[26:22]; s = ins[21:17]; t = ins[16:12];
        lg = (o < 14);
        im = (o == 1) || (o == 3) || (o == 12) || (o == 13);
        s1 = im ? d : s;
        s2 = im ? 5'd0 : t;
        rdy = (!m_valid || ordy) &&
              !(lg && (m_pending(s1, we, wa) || m_pending(s2, we, wa) || m_pending(d, we, wa)));
        @(negedge clk);
        check("in_ready", in_ready, rdy);
        check("out_valid", out_valid, m_valid);
        check("illegal", illegal, m_illegal);
        acc = v && rdy;
        if (acc && lg) begin
            e.op1      = m_read(s1, we, wa, wd);
            e.op2      = im ? 64'd0 : m_read(s2, we, wa, wd);
            e.op       = o;
            e.label    = ins[11:0];
            e.label_en = im;
            e.rd       = d;
            exp_q.push_back(e);
        end
        @(posedge clk);
        if (acc && lg)  m_valid = 1'b1;
        else if (ordy)  m_valid = 1'b0;
        if (we && wa != 0) begin
            m_regs[wa] = wd;
            m_busy[wa] = 1'b0;
        end
        if (acc && lg && d != 0) m_busy[d] = 1'b1;
        m_illegal = acc && !lg;
        #1;
    endtask

    task automatic idle(input logic we, input int wa, input logic [63:0] wd);
        cycle(1'b0, 32'd0, we, wa[4:0], wd, 1'b1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_illegal"}, illegal, 0);
        check({tag, "_operand1"}, operand1, 0);
        check({tag, "_operand2"}, operand2, 0);
        check({tag, "_op_label"}, {op, label, label_en, rd}, 0);
    endtask

    // Monitor: every issue consumed by execute must match the oldest expected issue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_issue", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("operand1", operand1, e.op1);
                    check("operand2", operand2, e.op2);
                    check("op", op, e.op);
                    check("label", label, e.label);
                    check("label_en", label_en, e.label_en);
                    check("rd", rd, e.rd);
                end
            end
        end
    end

    initial begin
        int          pend[$];
        logic [31:0] ins;
        logic        we, v, ordy;
        logic [4:0]  wa;
        int          o;

        rst_n = 1'b0; in_valid = 1'b0; instr = '0; wb_en = 1'b0;
        wb_addr = '0; wb_data = '0; out_ready = 1'b0;
        model_reset();
        #22;
        check_zero_outputs("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        check("reset_in_ready", in_ready, 1);

        // Load r1=5, r2=7, r4=10 through writeback.
        idle(1, 1, 64'd5);
        idle(1, 2, 64'd7);
        idle(1, 4, 64'd10);

        // add r3,r1,r2
        cycle(1, mk(0, 3, 1, 2, 0), 0, 0, 0, 1);
        check("add_valid", out_valid, 1);
        check("add_op1", operand1, 64'd5);
        check("add_op2", operand2, 64'd7);
        check("add_rd", rd, 3);
        check("add_label_en", label_en, 0);

        // addi r4, 0x123
        cycle(1, mk(1, 4, 9, 9, 'h123), 0, 0, 0, 1);
        check("addi_op1", operand1, 64'd10);
        check("addi_op2", operand2, 64'd0);
        check("addi_label", label, 12'h123);
        check("addi_label_en", label_en, 1);

        // sub r5,r3,r1 stalls on busy r3, then issues with bypassed writeback.
        repeat (4) begin
            cycle(1, mk(2, 5, 3, 1, 0), 0, 0, 0, 1);
            check("sub_stall_ready", in_ready, 0);
        end
        cycle(1, mk(2, 5, 3, 1, 0), 1, 3, 64'd12, 1);
        check("sub_bypass_op1", operand1, 64'd12);
        check("sub_op2", operand2, 64'd5);

        // Back-pressure: outputs hold while out_ready is low.
        repeat (3) begin
            cycle(1, mk(0, 6, 1, 2, 0), 0, 0, 0, 0);
            check("hold_op1", operand1, 64'd12);
            check("hold_rd", rd, 5);
            check("hold_valid", out_valid, 1);
        end
        cycle(1, mk(0, 6, 1, 2, 0), 0, 0, 0, 1);
        check("resume_rd6", rd, 6);
        cycle(1, mk(0, 7, 1, 2, 0), 0, 0, 0, 1);
        check("resume_rd7", rd, 7);
        idle(1, 4, 64'd40);
        idle(1, 5, 64'd50);
        idle(1, 6, 64'd60);
        idle(1, 7, 64'd70);

        // Illegal opcode is consumed and flagged for one cycle.
        cycle(1, mk(20, 3, 1, 2, 0), 0, 0, 0, 1);
        check("illegal_pulse", illegal, 1);
        check("illegal_no_issue", out_valid, 0);
        idle(0, 0, 0);
        check("illegal_drop", illegal, 0);

        // Reset with r3 pending and an issue waiting.
        cycle(1, mk(0, 3, 1, 2, 0), 0, 0, 0, 0);
        check("pre_reset_valid", out_valid, 1);
        rst_n = 1'b0;
        #2;
        check_zero_outputs("midreset");
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        cycle(1, mk(0, 6, 3, 0, 0), 0, 0, 0, 1);
        check("post_reset_valid", out_valid, 1);
        check("post_reset_op1", operand1, 64'd0);

        // Randomized traffic over a small register window to provoke hazards.
        for (int n = 0; n < 1500; n++) begin
            pend.delete();
            for (int r = 1; r < 8; r++) if (m_busy[r]) pend.push_back(r);
            we = 1'b0; wa = '0;
            if (pend.size() > 0 && $urandom_range(0, 2) == 0) begin
                we = 1'b1;
                wa = pend[$urandom_range(0, pend.size() - 1)];
            end else if ($urandom_range(0, 7) == 0) begin
                we = 1'b1;
                wa = 5'($urandom_range(0, 7));
            end
            o    = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 31) : $urandom_range(0, 13);
            ins  = mk(o, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 4095));
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            cycle(v, ins, we, wa, {$urandom, $urandom}, ordy);
        end

        repeat (3) idle(0, 0, 0);
        check("drain_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
